// File: rtl/text_screen_ctrl.sv
// rtl/text_screen_ctrl.sv - byte pacer, clear-screen burst expander and button arbiter for the text screen generator
module text_screen_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       btn_up_tick,
  input  logic       btn_down_tick,
  output logic [7:0] scr_data,
  output logic       scr_tick,
  output logic       scr_en,
  output logic       move_up_tick,
  output logic       move_down_tick,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TICK     = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_CLR_HOME = 3'd3;
  localparam logic [2:0] S_CLR_FILL = 3'd4;
  localparam logic [2:0] S_CLR_EOL  = 3'd5;

  localparam logic [7:0] GAP_LD   = 8'(GAP);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  localparam logic [7:0] CH_CLEAR = 8'h84;
  localparam logic [7:0] CH_HOME  = 8'h80;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;

  logic [2:0] state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       rx_ready_q, rx_ready_d;
  logic [7:0] scr_data_q, scr_data_d;
  logic       scr_tick_q, scr_tick_d;
  logic       scr_en_q, scr_en_d;
  logic       busy_q, busy_d;
  logic       up_pend_q, up_pend_d;
  logic       down_pend_q, down_pend_d;
  logic       move_up_q, move_up_d;
  logic       move_down_q, move_down_d;
  logic       eligible;

  // Next-state: each tick cycle loads the gap counter; the burst states
  // hold for the gap and then issue the next character of the fill pattern.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    col_d       = col_q;
    row_d       = row_q;
    rx_ready_d  = rx_ready_q;
    busy_d      = busy_q;
    scr_data_d  = scr_data_q;
    scr_tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        rx_ready_d = 1'b1;
        if (rx_valid && rx_ready_q) begin
          rx_ready_d = 1'b0;
          scr_tick_d = 1'b1;
          gap_d      = GAP_LD;
          if (rx_data == CH_CLEAR) begin
            state_d    = S_CLR_HOME;
            busy_d     = 1'b1;
            scr_data_d = CH_HOME;
            col_d      = 7'd0;
            row_d      = 5'd0;
          end else begin
            state_d    = S_TICK;
            scr_data_d = rx_data;
          end
        end
      end
      S_TICK, S_WAIT: begin
        if (gap_q <= 8'd1) begin
          state_d    = S_IDLE;
          rx_ready_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          gap_d   = gap_q - 8'd1;
        end
      end
      S_CLR_HOME: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else begin
          state_d    = S_CLR_FILL;
          col_d      = 7'd1;
          scr_tick_d = 1'b1;
          scr_data_d = CH_SPACE;
          gap_d      = GAP_LD;
        end
      end
      S_CLR_FILL: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (col_q == COL_LAST) begin
          state_d    = S_CLR_EOL;
          scr_tick_d = 1'b1;
          scr_data_d = CH_CR;
          gap_d      = GAP_LD;
        end else begin
          col_d      = col_q + 7'd1;
          scr_tick_d = 1'b1;
          scr_data_d = CH_SPACE;
          gap_d      = GAP_LD;
        end
      end
      S_CLR_EOL: begin
        // The last row ends one cycle early so busy/rx_ready land GAP cycles after the final tick.
        if (row_q == ROW_LAST && gap_q <= 8'd1) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          rx_ready_d = 1'b1;
        end else if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else begin
          state_d    = S_CLR_FILL;
          row_d      = row_q + 5'd1;
          col_d      = 7'd1;
          scr_tick_d = 1'b1;
          scr_data_d = CH_SPACE;
          gap_d      = GAP_LD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Button arbitration: forward only into cycles with no write tick and no burst; up wins over down.
  always_comb begin
    eligible    = !scr_tick_d && !busy_d;
    move_up_d   = up_pend_q && eligible;
    move_down_d = down_pend_q && eligible && !up_pend_q;
    up_pend_d   = (up_pend_q && !move_up_d) || btn_up_tick;
    down_pend_d = (down_pend_q && !move_down_d) || btn_down_tick;
    scr_en_d    = scr_en_q || scr_tick_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gap_q       <= 8'd0;
      col_q       <= 7'd0;
      row_q       <= 5'd0;
      rx_ready_q  <= 1'b0;
      scr_data_q  <= 8'h00;
      scr_tick_q  <= 1'b0;
      scr_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      up_pend_q   <= 1'b0;
      down_pend_q <= 1'b0;
      move_up_q   <= 1'b0;
      move_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rx_ready_q  <= rx_ready_d;
      scr_data_q  <= scr_data_d;
      scr_tick_q  <= scr_tick_d;
      scr_en_q    <= scr_en_d;
      busy_q      <= busy_d;
      up_pend_q   <= up_pend_d;
      down_pend_q <= down_pend_d;
      move_up_q   <= move_up_d;
      move_down_q <= move_down_d;
    end
  end

  assign rx_ready       = rx_ready_q;
  assign scr_data       = scr_data_q;
  assign scr_tick       = scr_tick_q;
  assign scr_en         = scr_en_q;
  assign busy           = busy_q;
  assign move_up_tick   = move_up_q;
  assign move_down_tick = move_down_q;

endmodule

// File: tb/tb_text_screen_ctrl.sv
// tb/tb_text_screen_ctrl.sv - scoreboard bench for text_screen_ctrl
module tb_text_screen_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       btn_up_tick = 1'b0;
  logic       btn_down_tick = 1'b0;
  logic [7:0] scr_data;
  logic       scr_tick;
  logic       scr_en;
  logic       move_up_tick;
  logic       move_down_tick;
  logic       busy;

  text_screen_ctrl #(.COLS(COLS), .ROWS(ROWS), .GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .btn_up_tick(btn_up_tick), .btn_down_tick(btn_down_tick),
    .scr_data(scr_data), .scr_tick(scr_tick), .scr_en(scr_en),
    .move_up_tick(move_up_tick), .move_down_tick(move_down_tick),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tick_count = 0;
  int cr_count = 0;
  int up_count = 0;
  int down_count = 0;
  int up_cyc = 0;
  int down_cyc = 0;
  int last_tick_cyc = 0;
  logic [7:0] exp_q[$];
  int tick_cyc_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor plus per-event protocol checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (scr_tick) begin
        tick_count++;
        last_tick_cyc = cyc;
        tick_cyc_q.push_back(cyc);
        if (scr_data == 8'h0D) cr_count++;
        check("tick_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("tick_data", 32'(scr_data), 32'(exp_q.pop_front()));
      end
      if (move_up_tick || move_down_tick) begin
        check("mv_excl", 32'(move_up_tick && move_down_tick), 0);
        check("mv_vs_tick", 32'(scr_tick), 0);
        check("mv_busy", 32'(busy), 0);
      end
      if (move_up_tick) begin up_count++; up_cyc = cyc; end
      if (move_down_tick) begin down_count++; down_cyc = cyc; end
      if (busy && rx_ready) check("rdy_in_burst", 32'(rx_ready), 0);
    end
  end

  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    @(negedge clk);
    while (!rx_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("send_timeout", int'(g < 100), 1);
    rx_data = b;
    rx_valid = 1'b1;
    if (b != 8'h84) exp_q.push_back(b);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic push_clear();
    exp_q.push_back(8'h80);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS - 1; c++) exp_q.push_back(8'h20);
      exp_q.push_back(8'h0D);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, c0, g, fall;
    logic ok;
    logic [7:0] stream [5];
    stream[0] = 8'h31; stream[1] = 8'h32; stream[2] = 8'h83; stream[3] = 8'h0D; stream[4] = 8'h7E;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_scr_data", 32'(scr_data), 0);
    check("rst_scr_tick", 32'(scr_tick), 0);
    check("rst_scr_en", 32'(scr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_move", 32'({move_up_tick, move_down_tick}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(rx_ready), 1);
    check("en_before_tick", 32'(scr_en), 0);

    // Single byte latency and ready timing
    send(8'h41);
    @(negedge clk);
    check("t1_tick", 32'(scr_tick), 1);
    check("t1_data", 32'(scr_data), 'h41);
    check("t1_rdy_low", 32'(rx_ready), 0);
    check("t1_en", 32'(scr_en), 1);
    @(negedge clk);
    check("t1_rdy_back", 32'(rx_ready), 1);
    check("t1_tick_off", 32'(scr_tick), 0);

    // Data held between ticks
    t0 = tick_count;
    send(8'h82);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (scr_data !== 8'h82) ok = 1'b0;
    end
    check("hold_82", 32'(ok), 1);
    check("hold_one_tick", tick_count - t0, 1);

    // Back-to-back stream with rx_valid held high
    t0 = tick_count;
    tick_cyc_q.delete();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_data = stream[i];
      rx_valid = 1'b1;
      exp_q.push_back(stream[i]);
      g = 0;
      while (!rx_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      check("stream_timeout", int'(g < 50), 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("stream_count", tick_count - t0, 5);
    if (tick_cyc_q.size() == 5)
      for (int i = 1; i < 5; i++) check("stream_spacing", tick_cyc_q[i] - tick_cyc_q[i-1], GAP + 1);

    // Clear burst with coincident button ticks mid-burst
    t0 = tick_count;
    c0 = cr_count;
    push_clear();
    send(8'h84);
    g = 0;
    while (busy && g < 8000) begin
      @(negedge clk);
      g++;
      if (g == 100) begin btn_up_tick = 1'b1; btn_down_tick = 1'b1; end
      if (g == 101) begin btn_up_tick = 1'b0; btn_down_tick = 1'b0; end
    end
    check("burst_timeout", int'(g < 8000), 1);
    fall = cyc;
    check("busy_fall_gap", fall - last_tick_cyc, GAP);
    check("burst_rdy_back", 32'(rx_ready), 1);
    repeat (5) @(negedge clk);
    check("burst_ticks", tick_count - t0, 1 + ROWS * COLS);
    check("burst_cr", cr_count - c0, ROWS);
    check("burst_q_empty", exp_q.size(), 0);
    check("up_once", up_count, 1);
    check("down_once", down_count, 1);
    check("up_after_busy", int'(up_cyc >= fall), 1);
    check("down_after_up", down_cyc - up_cyc, 1);

    // Reset in the middle of a burst
    t0 = tick_count;
    push_clear();
    send(8'h84);
    g = 0;
    while ((tick_count - t0) < 1000 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("fill_timeout", int'(g < 5000), 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_rdy", 32'(rx_ready), 0);
    check("mid_rst_data", 32'(scr_data), 0);
    check("mid_rst_tick", 32'(scr_tick), 0);
    check("mid_rst_en", 32'(scr_en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    t1 = tick_count;
    repeat (20) @(negedge clk);
    check("no_tick_after_rst", tick_count - t1, 0);
    check("busy_after_rst", 32'(busy), 0);
    send(8'h42);
    @(negedge clk);
    check("post_rst_tick", 32'(scr_tick), 1);
    check("post_rst_data", 32'(scr_data), 'h42);
    repeat (3) @(negedge clk);
    check("post_rst_count", tick_count - t1, 1);
    check("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
